// File: rtl/i2s_tx_feeder.sv
// I2S transmit feeder: sck/ws generation, stereo-pair FIFO and held output pair for the serializer.
// Build option I2S_HOLD_ON_UNDERRUN_EN: an empty-FIFO pop repeats the last pair instead of sending zeros.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | sck/ws held low, counters cleared, waiting for enable
// PRIME | one cycle; pops the first pair before the clocks start
// RUN   | sck/ws running; every ws 1->0 toggle pops the next pair
module i2s_tx_feeder #(
    parameter int DW    = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DIV   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_left,
    input  logic [DW-1:0] wr_right,
    output logic          sck,
    output logic          ws,
    output logic [DW-1:0] data_left,
    output logic [DW-1:0] data_right,
    output logic [AW:0]   fill_level,
    output logic          underrun,
    input  logic          underrun_clr
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DW - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state;
    logic [DCW-1:0]  div_cnt;
    logic [BCW-1:0]  bit_cnt;

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [2*DW-1:0] head;

    logic wr_acc;
    logic div_wrap;
    logic sck_fall;
    logic word_end;
    logic frame_start;
    logic pop_evt;
    logic fifo_empty;
    logic pop_do;

    assign wr_ready    = (count != FULL_CNT);
    assign fill_level  = count;
    assign wr_acc      = wr_valid && wr_ready;
    assign fifo_empty  = (count == '0);
    assign head        = mem[rd_ptr];

    assign div_wrap    = (state == ST_RUN) && (div_cnt == DIV_LAST);
    assign sck_fall    = div_wrap && sck;
    assign word_end    = sck_fall && (bit_cnt == BIT_LAST);
    assign frame_start = enable && word_end && ws;
    assign pop_evt     = ((state == ST_PRIME) && enable) || frame_start;
    // Emptiness is judged before this cycle's write, so a same-cycle write never rescues a pop.
    assign pop_do      = pop_evt && !fifo_empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= {wr_left, wr_right};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_do) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, pop_do})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            sck     <= 1'b0;
            ws      <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sck     <= 1'b0;
                    ws      <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (enable) begin
                        state <= ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    sck     <= 1'b0;
                    ws      <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= enable ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (!enable) begin
                        state   <= ST_IDLE;
                        sck     <= 1'b0;
                        ws      <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else if (div_wrap) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (sck) begin
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                ws      <= ~ws;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    sck     <= 1'b0;
                    ws      <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_left  <= '0;
            data_right <= '0;
            underrun   <= 1'b0;
        end else begin
            if (pop_evt) begin
                if (!fifo_empty) begin
                    data_left  <= head[2*DW-1:DW];
                    data_right <= head[DW-1:0];
                end else begin
`ifdef I2S_HOLD_ON_UNDERRUN_EN
                    data_left  <= data_left;
                    data_right <= data_right;
`else
                    data_left  <= '0;
                    data_right <= '0;
`endif
                end
            end
            if (pop_evt && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Bench for i2s_tx_feeder: queue-based frame model checked every cycle, plus directed literal checks.
module tb_i2s_tx_feeder;

    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DIV   = 2;
    localparam int FRAME = 4 * DIV * DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          wr_valid = 1'b0;
    logic          underrun_clr = 1'b0;
    logic [DW-1:0] wr_left = '0;
    logic [DW-1:0] wr_right = '0;
    logic          wr_ready;
    logic          sck;
    logic          ws;
    logic [DW-1:0] data_left;
    logic [DW-1:0] data_right;
    logic [AW:0]   fill_level;
    logic          underrun;

    always #5 clk = ~clk;

    i2s_tx_feeder #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .DIV(DIV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_left      (wr_left),
        .wr_right     (wr_right),
        .sck          (sck),
        .ws           (ws),
        .data_left    (data_left),
        .data_right   (data_right),
        .fill_level   (fill_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: mode 0 = stopped, 1 = priming, 2 = running; m_n counts clk cycles since clocks started.
    logic [2*DW-1:0] m_q[$];
    int              m_mode = 0;
    int              m_n = 0;
    logic [DW-1:0]   m_dl = '0;
    logic [DW-1:0]   m_dr = '0;
    logic            m_und = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                m_mode = 0;
                m_n = 0;
                m_dl = '0;
                m_dr = '0;
                m_und = 1'b0;
            end else begin
                bit pop;
                bit was_empty;
                bit wr_acc;
                logic [2*DW-1:0] pair;
                wr_acc    = wr_valid && (m_q.size() != DEPTH);
                was_empty = (m_q.size() == 0);
                pop = enable && ((m_mode == 1) || (m_mode == 2 && ((m_n + 1) % FRAME) == 0));
                if (pop && !was_empty) begin
                    pair = m_q.pop_front();
                    m_dl = pair[2*DW-1:DW];
                    m_dr = pair[DW-1:0];
                end else if (pop) begin
                    m_dl = '0;
                    m_dr = '0;
                end
                if (pop && was_empty) m_und = 1'b1;
                else if (underrun_clr) m_und = 1'b0;
                if (wr_acc) m_q.push_back({wr_left, wr_right});
                if (!enable) begin
                    m_mode = 0;
                    m_n = 0;
                end else if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    m_mode = 2;
                    m_n = 0;
                end else begin
                    m_n++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                logic e_sck;
                logic e_ws;
                e_sck = (m_mode == 2) && (((m_n / DIV) % 2) == 1);
                e_ws  = (m_mode == 2) && (((m_n / (2 * DIV * DW)) % 2) == 1);
                check("m_sck", sck, e_sck);
                check("m_ws", ws, e_ws);
                check("m_data_left", data_left, m_dl);
                check("m_data_right", data_right, m_dr);
                check("m_fill_level", fill_level, m_q.size());
                check("m_wr_ready", wr_ready, m_q.size() != DEPTH);
                check("m_underrun", underrun, m_und);
            end
        end
    end

    task automatic measure_timing(input string tag);
        int sr1 = -1;
        int sr2 = -1;
        int wr1 = -1;
        int wr2 = -1;
        logic ps;
        logic pw;
        ps = sck;
        pw = ws;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (sck && !ps) begin
                if (sr1 < 0) sr1 = i;
                else if (sr2 < 0) sr2 = i;
            end
            if (ws && !pw) begin
                if (wr1 < 0) wr1 = i;
                else if (wr2 < 0) begin
                    wr2 = i;
                    break;
                end
            end
            ps = sck;
            pw = ws;
        end
        check({tag, "_first_sck_rise"}, sr1, 2);
        check({tag, "_sck_period"}, sr2 - sr1, 4);
        check({tag, "_first_ws_rise"}, wr1, 64);
        check({tag, "_frame_period"}, wr2 - wr1, 128);
    endtask

    initial begin
        int hi;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Scenario 1: reset/idle values
        check("s1_sck", sck, 0);
        check("s1_ws", ws, 0);
        check("s1_data_left", data_left, 0);
        check("s1_data_right", data_right, 0);
        check("s1_fill", fill_level, 0);
        check("s1_wr_ready", wr_ready, 1);
        check("s1_underrun", underrun, 0);
        hi = 0;
        repeat (100) begin
            tick();
            if (sck) hi++;
        end
        check("s1_sck_high_cycles", hi, 0);

        // Scenario 2: prime pop and timing
        wr_left = 16'hA5A5;
        wr_right = 16'h5A5A;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("s2_fill_after_write", fill_level, 1);
        enable = 1'b1;
        tick();
        check("s2_fill_in_prime", fill_level, 1);
        tick();
        check("s2_data_left", data_left, 32'hA5A5);
        check("s2_data_right", data_right, 32'h5A5A);
        check("s2_fill_after_pop", fill_level, 0);
        measure_timing("s2");
        enable = 1'b0;
        tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("s2_underrun_cleared", underrun, 0);

        // Scenario 3: fill to full, overflow write dropped, order kept across wrap
        for (int i = 0; i <= 32; i++) begin
            wr_left = 16'(16'h1000 + i);
            wr_right = 16'(16'h2000 + i);
            wr_valid = 1'b1;
            tick();
            if (i == 31) begin
                check("s3_wr_ready_full", wr_ready, 0);
                check("s3_fill_full", fill_level, 32);
            end
        end
        wr_valid = 1'b0;
        check("s3_fill_after_33", fill_level, 32);
        for (int i = 0; i < 32; i++) begin
            enable = 1'b1;
            tick();
            tick();
            check($sformatf("s3_read_left_%0d", i), data_left, 32'(16'h1000 + i));
            check($sformatf("s3_read_right_%0d", i), data_right, 32'(16'h2000 + i));
            enable = 1'b0;
            tick();
        end
        check("s3_fill_drained", fill_level, 0);

        // Scenario 4: underrun set, clear, and set-wins-over-clear
        enable = 1'b1;
        tick();
        tick();
        check("s4_underrun_set", underrun, 1);
        check("s4_data_left_zero", data_left, 0);
        check("s4_data_right_zero", data_right, 0);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("s4_underrun_clr", underrun, 0);
        repeat (126) tick();
        check("s4_ws_before_frame", ws, 1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("s4_underrun_set_wins", underrun, 1);
        check("s4_ws_frame_start", ws, 0);

        // Scenario 5: write on the frame-start cycle with one pair stored
        wr_left = 16'hBEEF;
        wr_right = 16'hCAFE;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("s5_fill_one", fill_level, 1);
        repeat (126) tick();
        wr_left = 16'h1111;
        wr_right = 16'h2222;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("s5_fill_stays_one", fill_level, 1);
        check("s5_pop_older_left", data_left, 32'hBEEF);
        check("s5_pop_older_right", data_right, 32'hCAFE);

        // Scenario 6: disable mid-frame (bit 7 of right word), then restart
        repeat (94) tick();
        check("s6_pre_sck", sck, 1);
        check("s6_pre_ws", ws, 1);
        enable = 1'b0;
        tick();
        check("s6_sck_low", sck, 0);
        check("s6_ws_low", ws, 0);
        check("s6_fill_kept", fill_level, 1);
        check("s6_data_kept", data_left, 32'hBEEF);
        repeat (5) tick();
        enable = 1'b1;
        tick();
        tick();
        check("s6_prime_left", data_left, 32'h1111);
        check("s6_prime_right", data_right, 32'h2222);
        check("s6_fill_zero", fill_level, 0);
        measure_timing("s6");

        // Reset in the middle of operation
        wr_left = 16'h7777;
        wr_right = 16'h8888;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        enable = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_fill", fill_level, 0);
        check("rst_sck", sck, 0);
        check("rst_ws", ws, 0);
        check("rst_data_left", data_left, 0);
        check("rst_underrun", underrun, 0);
        check("rst_wr_ready", wr_ready, 1);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("rst_after_fill", fill_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_tx_feeder.md
Name: i2s_tx_feeder

Overview:
Upstream stage of the I2S serializer core. Generates the I2S bit clock (sck) and word select (ws) from the system clock, buffers stereo sample pairs written by the Avalon slave in a FIFO, and holds the current pair on data_left/data_right. The serializer consumes these outputs directly.

Parameters:
DW, 16, bits per channel sample; equals the serializer DW.
DEPTH, 32, FIFO depth in stereo pairs; power of 2, >= 2.
AW, 5, log2(DEPTH).
DIV, 4, clk cycles per sck half-period; >= 1.

Ports:
clk  input  1  system clock; all logic on posedge.
reset_n  input  1  reset, asynchronous, active-low.
enable  input  1  1 = run sck/ws and pop frames; 0 = stop.
wr_valid  input  1  write request for one stereo pair.
wr_ready  output  1  FIFO can accept a pair; combinational, = (count != DEPTH).
wr_left  input  DW  left sample to write.
wr_right  input  DW  right sample to write.
sck  output  1  I2S bit clock, registered.
ws  output  1  word select, 0 = left, 1 = right; registered.
data_left  output  DW  held left sample to serializer.
data_right  output  DW  held right sample to serializer.
fill_level  output  AW+1  pairs currently in FIFO, 0..DEPTH.
underrun  output  1  sticky; set when a frame pop finds FIFO empty.
underrun_clr  input  1  clears underrun.

Behaviour:
- Reset: sck=0, ws=0, data_left=data_right=0, fill_level=0, underrun=0, wr_ready=1, FIFO pointers 0, state IDLE.
- FIFO: write accepted when wr_valid && wr_ready. Pointers wrap modulo DEPTH. Write and pop in the same cycle leave count unchanged. No write-to-pop bypass: a pop from an empty FIFO is an underrun even if a write is accepted that cycle. Writes are accepted in every state.
- FSM states IDLE, PRIME, RUN.
- IDLE: sck=0, ws=0, div_cnt=0, bit_cnt=0. If enable=1, go to PRIME next cycle.
- PRIME: exactly one cycle. Performs a pop event, then goes to RUN. If enable=0, goes to IDLE instead and performs no pop.
- RUN: div_cnt counts 0..DIV-1. At DIV-1 it wraps and sck toggles.
- On each sck 1->0 toggle, bit_cnt increments. When bit_cnt==DW-1 at that toggle, bit_cnt resets to 0 and ws toggles in the same clk cycle. ws therefore changes only with falling sck, every DW sck periods.
- Frame start is the cycle ws toggles 1->0. It triggers a pop event.
- Pop event, FIFO non-empty: data_left/data_right load the head pair on the next edge; count decrements.
- Pop event, FIFO empty: data_left=data_right=0 and underrun is set.
- underrun: if set and underrun_clr occur in the same cycle, set wins.
- enable=0 in RUN: next cycle sck=0, ws=0, counters cleared, state IDLE. Holding registers and FIFO contents are retained. Re-enable goes through PRIME, which pops a new pair.
- data_left/data_right change only on pop events. Each update lands at least DIV clk cycles before the next sck rise, so the pair is stable while the serializer samples ws.
- After enable, ws starts at 0. The serializer first loads on the 0->1 ws change, so the first left slot after enable carries zeros. This is accepted behaviour.
- reset_n asserted mid-operation: immediate return to reset values. FIFO contents are discarded.

Optional Feature:
Macro I2S_HOLD_ON_UNDERRUN_EN.
- Defined: a pop event on an empty FIFO leaves data_left/data_right unchanged, repeating the last pair. underrun is still set.
- Undefined: data_left/data_right load 0 on underrun, as above.

Test Plan:
All scenarios use DW=16, DEPTH=32, DIV=2, macro undefined.
1. Reset with enable=0 -> sck=0, ws=0, data 0, fill_level=0, wr_ready=1, underrun=0; sck stays 0 for 100 clk.
2. Write (L=0xA5A5, R=0x5A5A), then raise enable -> PRIME pops it; data_left=0xA5A5 and data_right=0x5A5A one clk after PRIME; fill_level 1->0; sck period 4 clk; first ws rise 64 clk after RUN entry; frame period 128 clk.
3. With enable=0, write 33 pairs -> fill_level=32, wr_ready=0 after the 32nd; the 33rd is not stored; readback order is preserved across pointer wrap.
4. Enable with empty FIFO -> underrun=1, data 0. Assert underrun_clr alone -> underrun=0. Assert underrun_clr on the next frame-start cycle with FIFO empty -> underrun stays 1.
5. fill_level=1, wr_valid high on the frame-start cycle -> fill_level stays 1; the popped pair is the older entry.
6. Drop enable mid-frame with bit_cnt=7 -> next clk sck=0, ws=0, fill_level unchanged. Re-enable -> PRIME pop, and timing restarts exactly as in scenario 2.
